// File: rtl/bus_err_pkg.sv
// Shared types and default constants for the bus error drain/collector stage.
package bus_err_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BATCH = 2'd1,
      FIRE  = 2'd2
   } bus_err_coal_state_e;

   localparam int unsigned CntWidthDefault     = 16;
   localparam int unsigned TsWidthDefault      = 32;
   localparam int unsigned IrqThresholdDefault = 4;
   localparam int unsigned IrqTimeoutDefault   = 1024;

endpackage

// File: rtl/bus_err_irq_coalesce.sv
// Interrupt coalescing: fires after IrqThreshold captures or IrqTimeout cycles
// after the first capture of a batch, whichever comes first; held until acked.
module bus_err_irq_coalesce
   import bus_err_pkg::*;
#(
   parameter int unsigned CntWidth     = CntWidthDefault,
   parameter int unsigned IrqThreshold = IrqThresholdDefault,
   parameter int unsigned IrqTimeout   = IrqTimeoutDefault
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic cap_i,
   input  logic ack_i,
   output logic irq_o
);

   localparam int unsigned         TmrWidth = (IrqTimeout > 1) ? $clog2(IrqTimeout) : 1;
   localparam logic [TmrWidth-1:0] TmrLast  = TmrWidth'(IrqTimeout - 1);
   localparam logic [CntWidth:0]   Thresh   = (CntWidth + 1)'(IrqThreshold);

   bus_err_coal_state_e state_q, state_d;
   logic [CntWidth-1:0] batch_q, batch_d;
   logic [TmrWidth-1:0] timer_q, timer_d;
   logic                thresh_hit, timeout_hit;

   function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
      return (&v) ? v : v + CntWidth'(1);
   endfunction

   // One extra bit so batch + cap cannot wrap before the compare.
   assign thresh_hit  = ({1'b0, batch_q} + {{CntWidth{1'b0}}, cap_i}) >= Thresh;
   assign timeout_hit = (IrqTimeout != 0) && (timer_q == TmrLast);

   always_comb begin
      state_d = state_q;
      batch_d = batch_q;
      timer_d = timer_q;
      case (state_q)
         IDLE: begin
            if (cap_i) begin
               batch_d = CntWidth'(1);
               timer_d = '0;
               if (IrqThreshold == 1) state_d = FIRE;
               else                   state_d = BATCH;
            end
         end
         BATCH: begin
            timer_d = timer_q + TmrWidth'(1);
            if (cap_i) batch_d = sat_inc(batch_q);
            if (thresh_hit || timeout_hit) state_d = FIRE;
         end
         FIRE: begin
            if (cap_i) batch_d = sat_inc(batch_q);
            if (ack_i) begin
               if (cap_i) begin
                  state_d = BATCH;
                  batch_d = CntWidth'(1);
                  timer_d = '0;
               end else begin
                  state_d = IDLE;
                  batch_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         batch_q <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         batch_q <= batch_d;
         timer_q <= timer_d;
      end
   end

   assign irq_o = (state_q == FIRE);

endmodule

// File: rtl/bus_err_collector.sv
// Drains the upstream error FIFO into a registered record stream with stats and
// coalesced IRQ. Define BUS_ERR_COLLECTOR_TIMESTAMP_EN to build the timestamp counter.
module bus_err_collector
   import bus_err_pkg::*;
#(
   parameter int unsigned AddrWidth     = 48,
   parameter int unsigned MetaDataWidth = 1,
   parameter int unsigned ErrBits       = 3,
   parameter int unsigned CntWidth      = CntWidthDefault,
   parameter int unsigned TsWidth       = TsWidthDefault,
   parameter int unsigned IrqThreshold  = IrqThresholdDefault,
   parameter int unsigned IrqTimeout    = IrqTimeoutDefault
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     err_pending_i,
   input  logic [ErrBits-1:0]       err_code_i,
   input  logic [AddrWidth-1:0]     err_addr_i,
   input  logic [MetaDataWidth-1:0] err_meta_i,
   input  logic                     err_overflow_i,
   output logic                     err_pop_o,
   output logic                     rec_valid_o,
   input  logic                     rec_ready_i,
   output logic [ErrBits-1:0]       rec_code_o,
   output logic [AddrWidth-1:0]     rec_addr_o,
   output logic [MetaDataWidth-1:0] rec_meta_o,
   output logic [TsWidth-1:0]       rec_ts_o,
   output logic [CntWidth-1:0]      stat_total_o,
   output logic [CntWidth-1:0]      stat_drop_o,
   input  logic                     stat_clear_i,
   output logic                     irq_o,
   input  logic                     irq_ack_i
);

   typedef struct packed {
      logic [ErrBits-1:0]       code;
      logic [AddrWidth-1:0]     addr;
      logic [MetaDataWidth-1:0] meta;
      logic [TsWidth-1:0]       ts;
   } rec_t;

   rec_t                rec_q, rec_d;
   logic                rec_valid_q, rec_valid_d;
   logic [CntWidth-1:0] stat_total_q, stat_total_d;
   logic [CntWidth-1:0] stat_drop_q, stat_drop_d;
   logic                ovf_q, ovf_d;
   logic [TsWidth-1:0]  cur_ts;
   logic                cap;

   function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
      return (&v) ? v : v + CntWidth'(1);
   endfunction

`ifdef BUS_ERR_COLLECTOR_TIMESTAMP_EN
   logic [TsWidth-1:0] ts_q, ts_d;

   assign ts_d = ts_q + TsWidth'(1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ts_q <= '0;
      else         ts_q <= ts_d;
   end

   assign cur_ts = ts_q;
`else
   assign cur_ts = '0;
`endif

   // The FIFO head is always valid while pending, so pop and load happen together.
   assign cap       = err_pending_i & (~rec_valid_q | rec_ready_i);
   assign err_pop_o = cap;

   always_comb begin
      rec_d        = rec_q;
      rec_valid_d  = rec_valid_q;
      stat_total_d = stat_total_q;
      stat_drop_d  = stat_drop_q;
      ovf_d        = err_overflow_i;

      if (cap) begin
         rec_d.code  = err_code_i;
         rec_d.addr  = err_addr_i;
         rec_d.meta  = err_meta_i;
         rec_d.ts    = cur_ts;
         rec_valid_d = 1'b1;
      end else if (rec_ready_i) begin
         rec_valid_d = 1'b0;
      end

      if (stat_clear_i) begin
         stat_total_d = '0;
         stat_drop_d  = '0;
      end else begin
         if (cap)                       stat_total_d = sat_inc(stat_total_q);
         if (err_overflow_i && !ovf_q)  stat_drop_d  = sat_inc(stat_drop_q);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rec_q        <= '0;
         rec_valid_q  <= 1'b0;
         stat_total_q <= '0;
         stat_drop_q  <= '0;
         ovf_q        <= 1'b0;
      end else begin
         rec_q        <= rec_d;
         rec_valid_q  <= rec_valid_d;
         stat_total_q <= stat_total_d;
         stat_drop_q  <= stat_drop_d;
         ovf_q        <= ovf_d;
      end
   end

   bus_err_irq_coalesce #(
      .CntWidth     (CntWidth),
      .IrqThreshold (IrqThreshold),
      .IrqTimeout   (IrqTimeout)
   ) u_coal (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .cap_i  (cap),
      .ack_i  (irq_ack_i),
      .irq_o  (irq_o)
   );

   assign rec_valid_o  = rec_valid_q;
   assign rec_code_o   = rec_q.code;
   assign rec_addr_o   = rec_q.addr;
   assign rec_meta_o   = rec_q.meta;
   assign rec_ts_o     = rec_q.ts;
   assign stat_total_o = stat_total_q;
   assign stat_drop_o  = stat_drop_q;

endmodule

// File: tb/tb_bus_err_collector.sv
// Directed bench for bus_err_collector: capture, backpressure, IRQ coalescing,
// saturation and overflow counting, with a 4-bit counter build.
module tb_bus_err_collector;
   import bus_err_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        err_pending_i = 1'b0;
   logic [2:0]  err_code_i = '0;
   logic [47:0] err_addr_i = '0;
   logic [0:0]  err_meta_i = '0;
   logic        err_overflow_i = 1'b0;
   logic        err_pop_o;
   logic        rec_valid_o;
   logic        rec_ready_i = 1'b0;
   logic [2:0]  rec_code_o;
   logic [47:0] rec_addr_o;
   logic [0:0]  rec_meta_o;
   logic [31:0] rec_ts_o;
   logic [3:0]  stat_total_o;
   logic [3:0]  stat_drop_o;
   logic        stat_clear_i = 1'b0;
   logic        irq_o;
   logic        irq_ack_i = 1'b0;

   int passed = 0;
   int total  = 0;
   logic [31:0] exp_ts;

   bus_err_collector #(
      .AddrWidth(48), .MetaDataWidth(1), .ErrBits(3), .CntWidth(4),
      .TsWidth(32), .IrqThreshold(4), .IrqTimeout(16)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .err_pending_i(err_pending_i),
      .err_code_i(err_code_i), .err_addr_i(err_addr_i), .err_meta_i(err_meta_i),
      .err_overflow_i(err_overflow_i), .err_pop_o(err_pop_o),
      .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i),
      .rec_code_o(rec_code_o), .rec_addr_o(rec_addr_o), .rec_meta_o(rec_meta_o),
      .rec_ts_o(rec_ts_o), .stat_total_o(stat_total_o), .stat_drop_o(stat_drop_o),
      .stat_clear_i(stat_clear_i), .irq_o(irq_o), .irq_ack_i(irq_ack_i)
   );

   always #5 clk_i = ~clk_i;

`ifdef BUS_ERR_COLLECTOR_TIMESTAMP_EN
   logic [31:0] tb_cyc;
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) tb_cyc <= '0;
      else         tb_cyc <= tb_cyc + 32'd1;
   end
`endif

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      err_pending_i = 1'b0; err_code_i = '0; err_addr_i = '0; err_meta_i = '0;
      err_overflow_i = 1'b0; rec_ready_i = 1'b0; stat_clear_i = 1'b0; irq_ack_i = 1'b0;
      tick();
      rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      total++; if (rec_valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", rec_valid_o); else passed++;
      total++; if (rec_code_o !== 3'd0) $display("FAIL rst_code: got %h want 0", rec_code_o); else passed++;
      total++; if (rec_addr_o !== 48'd0) $display("FAIL rst_addr: got %h want 0", rec_addr_o); else passed++;
      total++; if (rec_meta_o !== 1'b0) $display("FAIL rst_meta: got %h want 0", rec_meta_o); else passed++;
      total++; if (rec_ts_o !== 32'd0) $display("FAIL rst_ts: got %h want 0", rec_ts_o); else passed++;
      total++; if (stat_total_o !== 4'd0) $display("FAIL rst_total: got %0d want 0", stat_total_o); else passed++;
      total++; if (stat_drop_o !== 4'd0) $display("FAIL rst_drop: got %0d want 0", stat_drop_o); else passed++;
      total++; if (irq_o !== 1'b0) $display("FAIL rst_irq: got %b want 0", irq_o); else passed++;
      total++; if (err_pop_o !== 1'b0) $display("FAIL rst_pop: got %b want 0", err_pop_o); else passed++;
      total++; if (dut.u_coal.state_q !== IDLE) $display("FAIL rst_state: got %0d want IDLE", dut.u_coal.state_q); else passed++;
      // capture something, then pull reset asynchronously mid-cycle
      err_pending_i = 1'b1; err_code_i = 3'd7; err_addr_i = 48'hABC; err_overflow_i = 1'b1;
      tick();
      err_pending_i = 1'b0; err_overflow_i = 1'b0;
      total++; if (rec_valid_o !== 1'b1) $display("FAIL midrst_pre_valid: got %b want 1", rec_valid_o); else passed++;
      #2;
      rst_ni = 1'b0;
      #1;
      total++; if (rec_valid_o !== 1'b0) $display("FAIL midrst_valid: got %b want 0", rec_valid_o); else passed++;
      total++; if (rec_addr_o !== 48'd0) $display("FAIL midrst_addr: got %h want 0", rec_addr_o); else passed++;
      total++; if (stat_total_o !== 4'd0) $display("FAIL midrst_total: got %0d want 0", stat_total_o); else passed++;
      total++; if (stat_drop_o !== 4'd0) $display("FAIL midrst_drop: got %0d want 0", stat_drop_o); else passed++;
      total++; if (dut.u_coal.state_q !== IDLE) $display("FAIL midrst_state: got %0d want IDLE", dut.u_coal.state_q); else passed++;
      tick();
      rst_ni = 1'b1;
   endtask

   task automatic test_single_timeout();
      do_reset();
      rec_ready_i = 1'b1;
      err_pending_i = 1'b1; err_code_i = 3'h2; err_addr_i = 48'h1000; err_meta_i = 1'b1;
      #1;
`ifdef BUS_ERR_COLLECTOR_TIMESTAMP_EN
      exp_ts = tb_cyc;
`else
      exp_ts = 32'd0;
`endif
      total++; if (err_pop_o !== 1'b1) $display("FAIL single_pop: got %b want 1", err_pop_o); else passed++;
      tick();
      err_pending_i = 1'b0; err_code_i = '0; err_addr_i = '0; err_meta_i = '0;
      #1;
      total++; if (err_pop_o !== 1'b0) $display("FAIL single_pop_end: got %b want 0", err_pop_o); else passed++;
      total++; if (rec_valid_o !== 1'b1) $display("FAIL single_valid: got %b want 1", rec_valid_o); else passed++;
      total++; if (rec_code_o !== 3'h2) $display("FAIL single_code: got %h want 2", rec_code_o); else passed++;
      total++; if (rec_addr_o !== 48'h1000) $display("FAIL single_addr: got %h want 1000", rec_addr_o); else passed++;
      total++; if (rec_meta_o !== 1'b1) $display("FAIL single_meta: got %h want 1", rec_meta_o); else passed++;
      total++; if (rec_ts_o !== exp_ts) $display("FAIL single_ts: got %0d want %0d", rec_ts_o, exp_ts); else passed++;
      total++; if (stat_total_o !== 4'd1) $display("FAIL single_total: got %0d want 1", stat_total_o); else passed++;
      total++; if (irq_o !== 1'b0) $display("FAIL single_irq: got %b want 0", irq_o); else passed++;
      tick();
      total++; if (rec_valid_o !== 1'b0) $display("FAIL single_valid_clr: got %b want 0", rec_valid_o); else passed++;
      // capture cycle C; batch starts at C+1 with timer 0, reaches 15 at C+16, irq at C+17
      repeat (14) tick();
      total++; if (irq_o !== 1'b0) $display("FAIL timeout_early: got %b want 0", irq_o); else passed++;
      tick();
      total++; if (irq_o !== 1'b1) $display("FAIL timeout_fire: got %b want 1", irq_o); else passed++;
      irq_ack_i = 1'b1;
      tick();
      irq_ack_i = 1'b0;
      total++; if (irq_o !== 1'b0) $display("FAIL timeout_ack: got %b want 0", irq_o); else passed++;
   endtask

   task automatic test_backpressure();
      do_reset();
      rec_ready_i = 1'b0;
      err_pending_i = 1'b1; err_code_i = 3'd1; err_addr_i = 48'hA0;
      #1;
      total++; if (err_pop_o !== 1'b1) $display("FAIL bp_pop_first: got %b want 1", err_pop_o); else passed++;
      tick();
      err_code_i = 3'd5; err_addr_i = 48'hB0;
      #1;
      total++; if (err_pop_o !== 1'b0) $display("FAIL bp_pop_held: got %b want 0", err_pop_o); else passed++;
      for (int i = 0; i < 10; i++) begin
         tick();
         total++;
         if (rec_valid_o !== 1'b1 || rec_code_o !== 3'd1 || rec_addr_o !== 48'hA0 || err_pop_o !== 1'b0)
            $display("FAIL bp_stable[%0d]: got v=%b code=%h addr=%h pop=%b want v=1 code=1 addr=a0 pop=0",
                     i, rec_valid_o, rec_code_o, rec_addr_o, err_pop_o);
         else passed++;
      end
      rec_ready_i = 1'b1;
      #1;
      total++; if (err_pop_o !== 1'b1) $display("FAIL bp_pop_ready: got %b want 1", err_pop_o); else passed++;
      tick();
      err_code_i = 3'd6; err_addr_i = 48'hC0;
      #1;
      total++; if (rec_valid_o !== 1'b1 || rec_code_o !== 3'd5 || rec_addr_o !== 48'hB0)
         $display("FAIL bp_rec2: got v=%b code=%h addr=%h want v=1 code=5 addr=b0", rec_valid_o, rec_code_o, rec_addr_o);
      else passed++;
      total++; if (err_pop_o !== 1'b1) $display("FAIL bp_pop_third: got %b want 1", err_pop_o); else passed++;
      tick();
      err_pending_i = 1'b0;
      #1;
      total++; if (rec_valid_o !== 1'b1 || rec_code_o !== 3'd6 || rec_addr_o !== 48'hC0)
         $display("FAIL bp_rec3: got v=%b code=%h addr=%h want v=1 code=6 addr=c0", rec_valid_o, rec_code_o, rec_addr_o);
      else passed++;
      tick();
      total++; if (rec_valid_o !== 1'b0) $display("FAIL bp_drained: got %b want 0", rec_valid_o); else passed++;
      total++; if (stat_total_o !== 4'd3) $display("FAIL bp_total: got %0d want 3", stat_total_o); else passed++;
   endtask

   task automatic fire_four();
      rec_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         err_pending_i = 1'b1; err_code_i = 3'(i); err_addr_i = 48'(i + 16);
         tick();
         if (i == 2) begin
            total++; if (irq_o !== 1'b0) $display("FAIL thr_irq_early: got %b want 0", irq_o); else passed++;
         end
      end
      err_pending_i = 1'b0;
   endtask

   task automatic test_threshold();
      do_reset();
      fire_four();
      total++; if (irq_o !== 1'b1) $display("FAIL thr_irq: got %b want 1", irq_o); else passed++;
      total++; if (dut.u_coal.batch_q !== 4'd4) $display("FAIL thr_batch: got %0d want 4", dut.u_coal.batch_q); else passed++;
      irq_ack_i = 1'b1;
      tick();
      irq_ack_i = 1'b0;
      total++; if (irq_o !== 1'b0) $display("FAIL thr_ack_irq: got %b want 0", irq_o); else passed++;
      total++; if (dut.u_coal.state_q !== IDLE) $display("FAIL thr_ack_state: got %0d want IDLE", dut.u_coal.state_q); else passed++;
      total++; if (dut.u_coal.batch_q !== 4'd0) $display("FAIL thr_ack_batch: got %0d want 0", dut.u_coal.batch_q); else passed++;
      irq_ack_i = 1'b1;
      tick();
      irq_ack_i = 1'b0;
      total++; if (dut.u_coal.state_q !== IDLE) $display("FAIL ack_idle_ignored: got %0d want IDLE", dut.u_coal.state_q); else passed++;
   endtask

   task automatic test_ack_collision();
      do_reset();
      fire_four();
      total++; if (irq_o !== 1'b1) $display("FAIL coll_pre_irq: got %b want 1", irq_o); else passed++;
      err_pending_i = 1'b1; irq_ack_i = 1'b1;
      tick();
      err_pending_i = 1'b0; irq_ack_i = 1'b0;
      total++; if (irq_o !== 1'b0) $display("FAIL coll_irq: got %b want 0", irq_o); else passed++;
      total++; if (dut.u_coal.state_q !== BATCH) $display("FAIL coll_state: got %0d want BATCH", dut.u_coal.state_q); else passed++;
      total++; if (dut.u_coal.batch_q !== 4'd1) $display("FAIL coll_batch: got %0d want 1", dut.u_coal.batch_q); else passed++;
      total++; if (stat_total_o !== 4'd5) $display("FAIL coll_total: got %0d want 5", stat_total_o); else passed++;
   endtask

   task automatic test_saturation_drops();
      logic [8:0] ovf_pat;
      do_reset();
      rec_ready_i = 1'b1;
      err_pending_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         err_addr_i = 48'(i);
         tick();
      end
      err_pending_i = 1'b0;
      total++; if (stat_total_o !== 4'd15) $display("FAIL sat_total: got %0d want 15", stat_total_o); else passed++;
      total++; if (dut.u_coal.batch_q !== 4'd15) $display("FAIL sat_batch: got %0d want 15", dut.u_coal.batch_q); else passed++;
      total++; if (irq_o !== 1'b1) $display("FAIL sat_irq: got %b want 1", irq_o); else passed++;
      // applied LSB first: 0,1,1,1,0,1,0,1,1 -> rising edges at bits 1, 5, 7
      ovf_pat = 9'b110101110;
      for (int i = 0; i < 9; i++) begin
         err_overflow_i = ovf_pat[i];
         tick();
      end
      err_overflow_i = 1'b0;
      tick();
      total++; if (stat_drop_o !== 4'd3) $display("FAIL drop_count: got %0d want 3", stat_drop_o); else passed++;
      err_pending_i = 1'b1; stat_clear_i = 1'b1; err_overflow_i = 1'b1;
      tick();
      err_pending_i = 1'b0; stat_clear_i = 1'b0; err_overflow_i = 1'b0;
      total++; if (stat_total_o !== 4'd0) $display("FAIL clr_total: got %0d want 0", stat_total_o); else passed++;
      total++; if (stat_drop_o !== 4'd0) $display("FAIL clr_drop: got %0d want 0", stat_drop_o); else passed++;
      tick();
      total++; if (stat_total_o !== 4'd0) $display("FAIL clr_hold: got %0d want 0", stat_total_o); else passed++;
   endtask

   initial begin
      test_reset();
      test_single_timeout();
      test_backpressure();
      test_threshold();
      test_ack_collision();
      test_saturation_drops();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
